// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the LED snake game.
// Provides LED width, FSM state enum, LFSR mask/seed and a one-hot helper.
package snake_pkg;

  localparam int          LED_W         = 8;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    SHOW,
    CLEAR
  } state_e;

  function automatic logic [LED_W-1:0] onehot(input logic [2:0] idx);
    logic [LED_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, reloads SEED on rst.
// Ports: clk, rst (sync, active-high), q[15:0] current state.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF,
  parameter logic [15:0] MASK = LFSR_MASK
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // An all-zero state would lock the LFSR up.
  localparam logic [15:0] SEED_NZ =
    (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]};
    if (q_q[0]) begin
      q_d = q_d ^ MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED_NZ;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rabbit_spawner.sv
// rabbit_spawner: places a one-hot rabbit off the snake, blanks it on eat.
// Ports: clk, rst, enable, snake_led, eaten -> rabbit_led, rabbit_valid, spawn.
module rabbit_spawner
  import snake_pkg::*;
#(
  parameter int unsigned RESPAWN_CYCLES = 1500000,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [LED_W-1:0] snake_led,
  input  logic             eaten,
  output logic [LED_W-1:0] rabbit_led,
  output logic             rabbit_valid,
  output logic             spawn
);

  localparam int CW = $clog2(RESPAWN_CYCLES + 1);
  // Counter runs 0..RESPAWN_CYCLES and parks there; with the PICK
  // cycle this puts the earliest new rabbit RESPAWN_CYCLES+2 edges
  // after the eat.
  localparam logic [CW-1:0] CNT_TC = CW'(RESPAWN_CYCLES);

  logic [15:0] lfsr;
  logic [2:0]  idx;
  logic        lfsr_unused;

  lfsr16 #(
    .SEED (LFSR_SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign idx         = lfsr[2:0];
  assign lfsr_unused = ^lfsr[15:3];

  state_e           state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             valid_q, valid_d;
  logic             spawn_q, spawn_d;
  logic             eaten_d_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eaten_rise;

  assign eaten_rise = eaten & ~eaten_d_q;

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    spawn_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      led_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = PICK;
          led_d   = '0;
        end
        PICK: begin
          if (!snake_led[idx]) begin
            state_d = SHOW;
            led_d   = onehot(idx);
            spawn_d = 1'b1;
          end
        end
        SHOW: begin
          if (eaten_rise) begin
            state_d = CLEAR;
            led_d   = '0;
            cnt_d   = '0;
          end
        end
        CLEAR: begin
          if (cnt_q != CNT_TC) begin
            cnt_d = cnt_q + CW'(1);
          end else if (!eaten) begin
            state_d = PICK;
          end
        end
        default: begin
          state_d = IDLE;
          led_d   = '0;
        end
      endcase
    end
    valid_d = (state_d == SHOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      led_q     <= '0;
      valid_q   <= 1'b0;
      spawn_q   <= 1'b0;
      eaten_d_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      valid_q   <= valid_d;
      spawn_q   <= spawn_d;
      eaten_d_q <= eaten;
      cnt_q     <= cnt_d;
    end
  end

  assign rabbit_led   = led_q;
  assign rabbit_valid = valid_q;
  assign spawn        = spawn_q;

endmodule

// File: tb/tb_rabbit_spawner.sv
// tb_rabbit_spawner: directed self-checking bench for rabbit_spawner.
// Uses RESPAWN_CYCLES=4 and a second instance seeded with zero.
module tb_rabbit_spawner;

  localparam int unsigned RC = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] snake_led;
  logic       eaten;
  logic [7:0] rabbit_led;
  logic       rabbit_valid;
  logic       spawn;
  logic [7:0] rabbit_led_z;
  logic       rabbit_valid_z;
  logic       spawn_z;

  int checks = 0;
  int errors = 0;

  logic [15:0] ma, ma_prev;
  logic [15:0] mz, mz_prev;
  logic [7:0]  exp_seq [6];

  rabbit_spawner #(
    .RESPAWN_CYCLES (RC),
    .LFSR_SEED      (16'hACE1)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .snake_led    (snake_led),
    .eaten        (eaten),
    .rabbit_led   (rabbit_led),
    .rabbit_valid (rabbit_valid),
    .spawn        (spawn)
  );

  rabbit_spawner #(
    .RESPAWN_CYCLES (RC),
    .LFSR_SEED      (16'h0000)
  ) u_zero (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .snake_led    (snake_led),
    .eaten        (eaten),
    .rabbit_led   (rabbit_led_z),
    .rabbit_valid (rabbit_valid_z),
    .spawn        (spawn_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    logic [15:0] s;
    s = {1'b0, v[15:1]};
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  // Reference LFSRs; *_prev holds the value the DUT used at the last edge.
  always @(posedge clk) begin
    ma_prev <= ma;
    mz_prev <= mz;
    if (rst) begin
      ma <= 16'hACE1;
      mz <= 16'h0001;
    end else begin
      ma <= lstep(ma);
      mz <= lstep(mz);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_spawn(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      tick;
      if (spawn === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic eat_pulse;
    eaten = 1'b1;
    tick;
    eaten = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    int sp;
    rst = 1'b1; enable = 1'b1; snake_led = 8'h01; eaten = 1'b0;
    repeat (2) begin
      tick;
      checks++;
      if (rabbit_led !== 8'h00 || rabbit_valid !== 1'b0 || spawn !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs led=%h valid=%b spawn=%b want 00/0/0",
                 rabbit_led, rabbit_valid, spawn);
      end
    end
    rst = 1'b0;
    wait_spawn(64, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL first_spawn_timeout spawn=%b want 1", spawn);
    end
    checks++;
    if (!$onehot(rabbit_led) || rabbit_led === 8'h01) begin
      errors++;
      $display("FAIL first_rabbit led=%h want one-hot not 01", rabbit_led);
    end
    sp = 0;
    repeat (10) begin
      tick;
      sp += int'(spawn);
    end
    checks++;
    if (sp !== 0 || rabbit_valid !== 1'b1) begin
      errors++;
      $display("FAIL spawn_once extra=%0d valid=%b want 0/1", sp, rabbit_valid);
    end
  endtask

  task automatic test_eat_respawn;
    bit ok;
    int bad;
    logic [7:0] held;
    snake_led = 8'h00;
    eat_pulse;
    checks++;
    if (rabbit_led !== 8'h00 || rabbit_valid !== 1'b0) begin
      errors++;
      $display("FAIL eat_blank led=%h valid=%b want 00/0", rabbit_led, rabbit_valid);
    end
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      bad += int'(rabbit_valid);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL respawn_early valid_cycles=%0d want 0", bad);
    end
    tick;
    checks++;
    if (rabbit_valid !== 1'b1 || spawn !== 1'b1 ||
        rabbit_led !== oh(ma_prev[2:0])) begin
      errors++;
      $display("FAIL respawn_edge6 led=%h valid=%b spawn=%b want %h/1/1",
               rabbit_led, rabbit_valid, spawn, oh(ma_prev[2:0]));
    end
    held = rabbit_led;
    snake_led = 8'hFF;
    repeat (3) tick;
    checks++;
    if (rabbit_led !== held || rabbit_valid !== 1'b1 || spawn !== 1'b0) begin
      errors++;
      $display("FAIL show_hold led=%h valid=%b spawn=%b want %h/1/0",
               rabbit_led, rabbit_valid, spawn, held);
    end
    snake_led = 8'h5A;
    eat_pulse;
    wait_spawn(200, ok);
    checks++;
    if (!ok || !$onehot(rabbit_led) || (rabbit_led & snake_led) !== 8'h00) begin
      errors++;
      $display("FAIL avoid_snake led=%h snake=%h ok=%b want one-hot off snake",
               rabbit_led, snake_led, ok);
    end
  endtask

  task automatic test_long_eaten;
    int vis;
    int sp;
    snake_led = 8'h00;
    eaten = 1'b1;
    vis = 0; sp = 0;
    repeat (10) begin
      tick;
      vis += int'(rabbit_valid);
      sp  += int'(spawn);
    end
    checks++;
    if (vis !== 0 || sp !== 0) begin
      errors++;
      $display("FAIL long_eaten_hold valid=%0d spawn=%0d want 0/0", vis, sp);
    end
    eaten = 1'b0;
    tick;
    checks++;
    if (rabbit_valid !== 1'b0) begin
      errors++;
      $display("FAIL long_eaten_pick valid=%b want 0", rabbit_valid);
    end
    tick;
    checks++;
    if (rabbit_valid !== 1'b1 || spawn !== 1'b1) begin
      errors++;
      $display("FAIL long_eaten_respawn valid=%b spawn=%b want 1/1",
               rabbit_valid, spawn);
    end
  endtask

  task automatic test_occupancy;
    bit ok;
    int bad;
    int tmo;
    snake_led = 8'hFE;
    bad = 0; tmo = 0;
    for (int i = 0; i < 200; i++) begin
      eat_pulse;
      wait_spawn(300, ok);
      if (!ok) tmo++;
      else if (rabbit_led !== 8'h01) bad++;
    end
    checks++;
    if (tmo !== 0) begin
      errors++;
      $display("FAIL occupancy_timeout count=%0d want 0", tmo);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL occupancy_led wrong=%0d want 0", bad);
    end
    snake_led = 8'hFF;
    eat_pulse;
    bad = 0;
    repeat (1000) begin
      tick;
      if (rabbit_valid !== 1'b0 || rabbit_led !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_board shown_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_enable_drop;
    int bad;
    snake_led = 8'h00;
    tick; tick;
    checks++;
    if (rabbit_valid !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre_show valid=%b want 1", rabbit_valid);
    end
    eat_pulse;
    tick;
    enable = 1'b0; eaten = 1'b1;
    tick;
    checks++;
    if (rabbit_led !== 8'h00 || rabbit_valid !== 1'b0 || spawn !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear led=%h valid=%b spawn=%b want 00/0/0",
               rabbit_led, rabbit_valid, spawn);
    end
    eaten = 1'b0;
    bad = 0;
    repeat (3) begin
      tick;
      if (rabbit_valid !== 1'b0 || rabbit_led !== 8'h00) bad++;
    end
    enable = 1'b1;
    tick;
    if (rabbit_valid !== 1'b0) bad++;
    tick;
    checks++;
    if (bad !== 0 || rabbit_valid !== 1'b1 || spawn !== 1'b1 ||
        rabbit_led !== oh(ma_prev[2:0])) begin
      errors++;
      $display("FAIL drop_clear_restart bad=%0d led=%h valid=%b want %h/1",
               bad, rabbit_led, rabbit_valid, oh(ma_prev[2:0]));
    end
    tick;
    enable = 1'b0; eaten = 1'b1;
    tick;
    checks++;
    if (rabbit_led !== 8'h00 || rabbit_valid !== 1'b0 || spawn !== 1'b0) begin
      errors++;
      $display("FAIL drop_show led=%h valid=%b spawn=%b want 00/0/0",
               rabbit_led, rabbit_valid, spawn);
    end
    eaten = 1'b0;
    bad = 0;
    repeat (5) begin
      tick;
      if (rabbit_valid !== 1'b0 || rabbit_led !== 8'h00) bad++;
    end
    enable = 1'b1;
    tick;
    if (rabbit_valid !== 1'b0) bad++;
    tick;
    checks++;
    if (bad !== 0 || rabbit_valid !== 1'b1 || spawn !== 1'b1) begin
      errors++;
      $display("FAIL drop_show_restart bad=%0d valid=%b spawn=%b want 0/1/1",
               bad, rabbit_valid, spawn);
    end
  endtask

  task automatic test_determinism;
    bit ok;
    int bad;
    int badz;
    for (int run = 0; run < 2; run++) begin
      rst = 1'b1; enable = 1'b1; snake_led = 8'h00; eaten = 1'b0;
      tick; tick;
      rst = 1'b0;
      bad = 0; badz = 0;
      for (int i = 0; i < 6; i++) begin
        wait_spawn(40, ok);
        if (!ok || rabbit_led !== oh(ma_prev[2:0])) bad++;
        if (spawn_z !== 1'b1 || rabbit_led_z !== oh(mz_prev[2:0])) badz++;
        if (run == 0) exp_seq[i] = oh(ma_prev[2:0]);
        else if (rabbit_led !== exp_seq[i]) bad++;
        repeat (i) tick;
        eat_pulse;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL determinism_run%0d wrong=%0d want 0", run, bad);
      end
      checks++;
      if (badz !== 0) begin
        errors++;
        $display("FAIL seed_zero_run%0d wrong=%0d want 0", run, badz);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; snake_led = 8'h00; eaten = 1'b0;
    test_reset;
    test_eat_respawn;
    test_long_eaten;
    test_occupancy;
    test_enable_drop;
    test_determinism;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
